// File: rtl/wb_master_bridge.sv
// ============================================================================
// wb_master_bridge: valid/ready request/response port to Wishbone classic master
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  timeout_count,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            bus_active, bus_active_nxt;
  logic [31:0]     adr_nxt, dat_nxt, rdata_nxt;
  logic [3:0]      sel_nxt;
  logic            we_nxt, rvalid_nxt, err_nxt;
  logic [7:0]      tc_nxt;

  assign req_ready = (state == IDLE);
  // CYC_O and STB_O are always asserted together for single-beat cycles.
  assign CYC_O     = bus_active;
  assign STB_O     = bus_active;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus_active    <= 1'b0;
      ADR_O         <= '0;
      DAT_O         <= '0;
      SEL_O         <= '0;
      WE_O          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus_active    <= bus_active_nxt;
      ADR_O         <= adr_nxt;
      DAT_O         <= dat_nxt;
      SEL_O         <= sel_nxt;
      WE_O          <= we_nxt;
      rsp_valid     <= rvalid_nxt;
      rsp_rdata     <= rdata_nxt;
      rsp_err       <= err_nxt;
      timeout_count <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bus_active_nxt = bus_active;
    adr_nxt        = ADR_O;
    dat_nxt        = DAT_O;
    sel_nxt        = SEL_O;
    we_nxt         = WE_O;
    rvalid_nxt     = rsp_valid;
    rdata_nxt      = rsp_rdata;
    err_nxt        = rsp_err;
    tc_nxt         = timeout_count;

    case (state)
      IDLE: begin
        if (req_valid) begin
          adr_nxt        = req_addr;
          dat_nxt        = req_we ? req_wdata : 32'd0;
          sel_nxt        = req_sel;
          we_nxt         = req_we;
          bus_active_nxt = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = BUS;
        end
      end
      BUS: begin
        // An ACK on the final timeout edge still completes normally.
        if (ACK_I) begin
          bus_active_nxt = 1'b0;
          rdata_nxt      = WE_O ? 32'd0 : DAT_I;
          err_nxt        = 1'b0;
          rvalid_nxt     = 1'b1;
          state_nxt      = RESP;
        end else if (cnt == TO_LAST) begin
          bus_active_nxt = 1'b0;
          rdata_nxt      = 32'd0;
          err_nxt        = 1'b1;
          rvalid_nxt     = 1'b1;
          if (timeout_count != 8'hFF) begin
            tc_nxt = timeout_count + 8'd1;
          end
          state_nxt      = RESP;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_nxt = 1'b0;
          err_nxt    = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
// ============================================================================
// tb_wb_master_bridge: scoreboard bench for wb_master_bridge (TIMEOUT_CYCLES=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_master_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  timeout_count;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O, STB_O, CYC_O, ACK_I;

  wb_master_bridge #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .timeout_count(timeout_count),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  tc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
    int          len;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tc_model = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops an expectation for each new response, then checks hold stability.
  initial begin
    rsp_t cur;
    bit   have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rsp_valid === 1'b1) begin
        check("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        if (!have_cur) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          end else begin
            cur = rsp_q.pop_front();
            have_cur = 1'b1;
            check("rsp_rdata", rsp_rdata, cur.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
            check("timeout_count", {24'd0, timeout_count}, {24'd0, cur.tc});
          end
        end else begin
          check("rsp_rdata_stable", rsp_rdata, cur.rdata);
          check("rsp_err_stable", {31'd0, rsp_err}, {31'd0, cur.err});
        end
        if (rsp_ready === 1'b1) have_cur = 1'b0;
      end
    end
  end

  // Bus monitor: checks fields for each strobe window and its length.
  initial begin
    bus_t cur;
    bit   prev_stb = 1'b0;
    bit   have_cur = 1'b0;
    int   cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (CYC_O !== STB_O) check("cyc_eq_stb", {31'd0, CYC_O}, {31'd0, STB_O});
        if (STB_O === 1'b1) begin
          if (!prev_stb) begin
            cnt = 0;
            have_cur = (bus_q.size() != 0);
            if (have_cur) cur = bus_q.pop_front();
            else check("unexpected_stb", {31'd0, STB_O}, 32'd0);
          end
          cnt++;
          if (have_cur) begin
            check("ADR_O", ADR_O, cur.addr);
            check("DAT_O", DAT_O, cur.data);
            check("SEL_O", {28'd0, SEL_O}, {28'd0, cur.sel});
            check("WE_O", {31'd0, WE_O}, {31'd0, cur.we});
          end
        end else if (prev_stb && have_cur) begin
          check("stb_length", cnt, cur.len);
          have_cur = 1'b0;
        end
        prev_stb = (STB_O === 1'b1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_stb_cyc"}, {30'd0, STB_O, CYC_O}, 32'd0);
    check({tag, "_adr_dat"}, ADR_O | DAT_O | rsp_rdata, 32'd0);
    check({tag, "_sel_we_err"}, {26'd0, SEL_O, WE_O, rsp_err}, 32'd0);
    check({tag, "_timeout_count"}, {24'd0, timeout_count}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // ack_at: strobe cycle (1-based) in which the slave acks; 0 means never.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int ack_at, input int hold);
    bit acked;
    bit done;
    int k;
    rsp_t r;
    bus_t b;
    acked = (ack_at >= 1) && (ack_at <= T);
    if (!acked && tc_model < 255) tc_model++;
    r.rdata = (acked && !we) ? dat : 32'd0;
    r.err   = !acked;
    r.tc    = 8'(tc_model);
    b.addr  = addr;
    b.data  = we ? wdata : 32'd0;
    b.sel   = sel;
    b.we    = we;
    b.len   = acked ? ack_at : T;
    rsp_q.push_back(r);
    bus_q.push_back(b);

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_sel = 4'($urandom);

    done = 1'b0;
    k = 1;
    while (!done && k <= T + 3) begin
      ACK_I = (k == ack_at);
      DAT_I = (k == ack_at) ? dat : $urandom;
      @(posedge clk); #1;
      ACK_I = 1'b0;
      if (STB_O !== 1'b1) done = 1'b1;
      else k++;
    end
    check("bus_completed", {31'd0, done}, 32'd1);
    check("rsp_valid_after_bus", {31'd0, rsp_valid}, 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_rsp", {31'd0, req_ready}, 32'd1);
    check("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    rsp_ready = 1'b0; DAT_I = '0; ACK_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    mon_en = 1'b1;

    do_txn(1'b0, 32'h3000_0010, 32'h0, 32'hDEAD_BEEF, 4'hF, 3, 0);
    do_txn(1'b1, 32'h3000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 4'h3, 1, 0);
    do_txn(1'b0, 32'h3000_0030, 32'h0, 32'h5555_AAAA, 4'hF, 0, 0);
    do_txn(1'b0, 32'h3000_0040, 32'h0, 32'hCAFE_F00D, 4'hC, T, 0);

    // Spurious ACK in IDLE must not create a response.
    ACK_I = 1'b1; DAT_I = 32'hBAD0_BAD0;
    repeat (3) begin @(posedge clk); #1; end
    ACK_I = 1'b0;
    check("spurious_ack_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("spurious_ack_idle", {31'd0, req_ready}, 32'd1);

    do_txn(1'b0, 32'h3000_0050, 32'h0, 32'h0BAD_CAFE, 4'h1, 2, 5);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, T + 2)), int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 260; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 0, 0);
    end
    check("timeout_saturated", {24'd0, timeout_count}, 32'd255);

    // Reset during the second strobe cycle aborts the request.
    begin
      bus_t b;
      b.addr = 32'h4000_0000; b.data = 32'h0; b.sel = 4'hF; b.we = 1'b0; b.len = 2;
      bus_q.push_back(b);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0000; req_sel = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("stb_before_reset", {31'd0, STB_O}, 32'd1);
      nrst = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      tc_model = 0;
      check_reset_outputs("midbus_reset");
      ACK_I = 1'b1; DAT_I = 32'h1111_2222;
      @(posedge clk); #1;
      ACK_I = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
    end

    do_txn(1'b1, 32'h5000_0000, 32'hA5A5_5A5A, 32'h0, 4'h6, 2, 1);

    repeat (2) @(posedge clk);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
